// File: rtl/leitor_matriz_botoes.sv
// leitor_matriz_botoes: 2x4 active-low button matrix scanner with
// frame-based debouncing and one-cycle press events.
module leitor_matriz_botoes #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] colunas_entrada,
    output logic [1:0] linhas_varredura,
    output logic [7:0] botoes,
    output logic [7:0] pulso,
    output logic       quadro_fim,
    output logic [1:0] db_estado
);

    localparam logic [1:0] INICIO   = 2'b00;
    localparam logic [1:0] LINHA0   = 2'b01;
    localparam logic [1:0] LINHA1   = 2'b10;
    localparam logic [1:0] ATUALIZA = 2'b11;

    localparam logic [7:0] ULT_CICLO = 8'(SCAN_DIV - 1);
    localparam logic [3:0] EST_MAX   = 4'(DEBOUNCE_SCANS - 1);

    logic [1:0] estado_q, estado_d;
    logic [7:0] cont_q, cont_d;
    logic [3:0] sinc1_q, sinc2_q;
    logic [7:0] quadro_q, quadro_d;
    logic [7:0] anterior_q, anterior_d;
    logic [3:0] estavel_q, estavel_d;
    logic [7:0] botoes_q, botoes_d;
    logic [7:0] pulso_q, pulso_d;
    logic       fim_q, fim_d;
    logic [1:0] linhas_q, linhas_d;
    logic       fim_linha;

    assign fim_linha = (cont_q == ULT_CICLO);

    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q + 8'd1;
        quadro_d   = quadro_q;
        anterior_d = anterior_q;
        estavel_d  = estavel_q;
        botoes_d   = botoes_q;
        pulso_d    = '0;
        unique case (estado_q)
            INICIO: estado_d = LINHA0;
            LINHA0: begin
                if (fim_linha) begin
                    estado_d      = LINHA1;
                    quadro_d[3:0] = ~sinc2_q;
                end
            end
            LINHA1: begin
                if (fim_linha) begin
                    estado_d      = ATUALIZA;
                    quadro_d[7:4] = ~sinc2_q;
                end
            end
            ATUALIZA: begin
                estado_d   = LINHA0;
                anterior_d = quadro_q;
                if (quadro_q == anterior_q) begin
                    if (estavel_q != EST_MAX)
                        estavel_d = estavel_q + 4'd1;
                end else begin
                    estavel_d = '0;
                end
                // Accept only once the frame has been seen unchanged long enough
                if (estavel_d == EST_MAX) begin
                    botoes_d = quadro_q;
                    pulso_d  = quadro_q & ~botoes_q;
                end
            end
            default: estado_d = INICIO;
        endcase
        if (estado_d != estado_q)
            cont_d = '0;
    end

    // Row drive and strobe are registered from the next state to stay glitch-free
    always_comb begin
        linhas_d = 2'b11;
        unique case (estado_d)
            LINHA0:  linhas_d = 2'b10;
            LINHA1:  linhas_d = 2'b01;
            default: linhas_d = 2'b11;
        endcase
        fim_d = (estado_d == ATUALIZA);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= INICIO;
            cont_q     <= '0;
            sinc1_q    <= 4'b1111;
            sinc2_q    <= 4'b1111;
            quadro_q   <= '0;
            anterior_q <= '0;
            estavel_q  <= '0;
            botoes_q   <= '0;
            pulso_q    <= '0;
            fim_q      <= 1'b0;
            linhas_q   <= 2'b11;
        end else begin
            estado_q   <= estado_d;
            cont_q     <= cont_d;
            sinc1_q    <= colunas_entrada;
            sinc2_q    <= sinc1_q;
            quadro_q   <= quadro_d;
            anterior_q <= anterior_d;
            estavel_q  <= estavel_d;
            botoes_q   <= botoes_d;
            pulso_q    <= pulso_d;
            fim_q      <= fim_d;
            linhas_q   <= linhas_d;
        end
    end

    assign linhas_varredura = linhas_q;
    assign botoes           = botoes_q;
    assign pulso            = pulso_q;
    assign quadro_fim       = fim_q;
    assign db_estado        = estado_q;

endmodule

// File: tb/tb_leitor_matriz_botoes.sv
// tb_leitor_matriz_botoes: directed checks of scanning, debounce,
// press pulses, releases and mid-frame reset.
module tb_leitor_matriz_botoes;

    logic       clock;
    logic       reset;
    logic [3:0] colunas_entrada;
    logic [1:0] linhas_varredura;
    logic [7:0] botoes;
    logic [7:0] pulso;
    logic       quadro_fim;
    logic [1:0] db_estado;

    logic [7:0] teclas;
    int n_cmp;
    int n_err;
    int n_pulsos;
    int base;

    leitor_matriz_botoes #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .colunas_entrada (colunas_entrada),
        .linhas_varredura(linhas_varredura),
        .botoes          (botoes),
        .pulso           (pulso),
        .quadro_fim      (quadro_fim),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad model: a driven (low) row pulls the columns of its pressed keys low
    always_comb begin
        for (int c = 0; c < 4; c++)
            colunas_entrada[c] = ~((~linhas_varredura[0] & teclas[c]) |
                                   (~linhas_varredura[1] & teclas[4+c]));
    end

    initial n_pulsos = 0;
    always @(negedge clock)
        if (pulso != 8'h00)
            n_pulsos = n_pulsos + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ends at the negedge just after the next ATUALIZA edge
    task automatic frame();
        int k;
        k = 0;
        while (quadro_fim !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (k >= 20)
            check("frame_timeout", 32'(k), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        int per;
        n_cmp  = 0;
        n_err  = 0;
        teclas = 8'h00;
        reset  = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_linhas", 32'(linhas_varredura), 32'h3);
        check("rst_botoes", 32'(botoes), 32'h00);
        check("rst_pulso", 32'(pulso), 32'h00);
        check("rst_estado", 32'(db_estado), 32'h0);
        check("rst_fim", 32'(quadro_fim), 32'h0);

        reset = 1'b1;
        @(negedge clock);
        check("l0_estado", 32'(db_estado), 32'h1);
        check("l0_linhas", 32'(linhas_varredura), 32'h2);
        repeat (4) @(negedge clock);
        check("l1_linhas", 32'(linhas_varredura), 32'h1);

        frame();
        per = 1;
        while (quadro_fim !== 1'b1 && per < 30) begin
            @(negedge clock);
            per++;
        end
        check("periodo", 32'(per), 32'd9);
        check("atu_estado", 32'(db_estado), 32'h3);
        @(negedge clock);
        frame();
        frame();

        // Key 6 held steady
        base = n_pulsos;
        teclas = 8'h40;
        frame();
        frame();
        check("k6_cedo", 32'(botoes), 32'h00);
        frame();
        check("k6_botoes", 32'(botoes), 32'h40);
        check("k6_pulso", 32'(pulso), 32'h40);
        @(negedge clock);
        check("k6_pulso_fim", 32'(pulso), 32'h00);
        frame();
        frame();
        frame();
        check("k6_um_pulso", 32'(n_pulsos - base), 32'd1);
        check("k6_mantido", 32'(botoes), 32'h40);

        // Release key 6
        base = n_pulsos;
        teclas = 8'h00;
        frame();
        frame();
        check("sol_mantido", 32'(botoes), 32'h40);
        frame();
        check("sol_botoes", 32'(botoes), 32'h00);
        check("sol_sem_pulso", 32'(n_pulsos - base), 32'd0);

        // Key 6 bouncing frame by frame
        base = n_pulsos;
        for (int i = 0; i < 6; i++) begin
            teclas = (i % 2 == 0) ? 8'h40 : 8'h00;
            frame();
        end
        check("ric_botoes", 32'(botoes), 32'h00);
        teclas = 8'h00;
        frame();
        frame();
        frame();
        check("ric_fim", 32'(botoes), 32'h00);
        check("ric_sem_pulso", 32'(n_pulsos - base), 32'd0);

        // Keys 0 and 7 together
        base = n_pulsos;
        teclas = 8'h81;
        frame();
        frame();
        frame();
        check("k07_pulso", 32'(pulso), 32'h81);
        check("k07_botoes", 32'(botoes), 32'h81);
        frame();
        check("k07_um_pulso", 32'(n_pulsos - base), 32'd1);

        // Release key 7 only
        base = n_pulsos;
        teclas = 8'h01;
        frame();
        frame();
        frame();
        check("sol7_botoes", 32'(botoes), 32'h01);
        check("sol7_sem_pulso", 32'(n_pulsos - base), 32'd0);

        // Reset during LINHA1 with key 3 held
        base = n_pulsos;
        teclas = 8'h08;
        per = 0;
        while (db_estado !== 2'b10 && per < 20) begin
            @(negedge clock);
            per++;
        end
        check("espera_l1", 32'(db_estado), 32'h2);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("mrst_botoes", 32'(botoes), 32'h00);
        check("mrst_pulso", 32'(pulso), 32'h00);
        check("mrst_linhas", 32'(linhas_varredura), 32'h3);
        check("mrst_estado", 32'(db_estado), 32'h0);
        frame();
        frame();
        check("k3_cedo", 32'(botoes), 32'h00);
        frame();
        check("k3_pulso", 32'(pulso), 32'h08);
        check("k3_botoes", 32'(botoes), 32'h08);
        frame();
        check("k3_um_pulso", 32'(n_pulsos - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
